// File: rtl/rsp_s2_dma_ahbic_pkg.sv
// Shared types and encodings for the rsp_s2_dma AHB-Lite interconnect.
// HTRANS/HBURST/HRESP codes, input-stage state and the address-phase bundle.
package rsp_s2_dma_ahbic_pkg;

    localparam int AHB_AW = 32;
    localparam int AHB_MW = 4;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } in_state_e;

    typedef struct packed {
        logic [AHB_AW-1:0] addr;
        htrans_e           trans;
        logic              write;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic [AHB_MW-1:0] master;
        logic              mastlock;
    } ahb_ctrl_t;

    // A broken burst is replayed as independent NONSEQ SINGLE beats;
    // BUSY has no meaning outside a burst so it is shown as IDLE.
    function automatic ahb_ctrl_t brk_convert(input ahb_ctrl_t c);
        ahb_ctrl_t r;
        r = c;
        if (c.trans == TR_SEQ) begin
            r.trans = TR_NONSEQ;
        end else if (c.trans == TR_BUSY) begin
            r.trans = TR_IDLE;
        end
        r.burst = BURST_SINGLE;
        return r;
    endfunction

endpackage

// File: rtl/rsp_s2_dma_ahbic_in_reg.sv
// Address-phase holding register for the interconnect input stage.
// Selects live or held control and applies the burst-break conversion.
module rsp_s2_dma_ahbic_in_reg
    import rsp_s2_dma_ahbic_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      cap_en,
    input  logic      hold,
    input  logic      hready,
    input  ahb_ctrl_t live_i,
    output ahb_ctrl_t ctrl_o
);

    ahb_ctrl_t ctrl_q;
    ahb_ctrl_t ctrl_d;
    logic      brk_q;
    logic      brk_d;
    logic      brk_clr;
    logic      brk_eff;
    ahb_ctrl_t path;

    // A live NONSEQ/IDLE with HREADY high starts a fresh sequence,
    // so it must itself be passed unmodified in that same cycle.
    assign brk_clr = hready &&
                     (live_i.trans == TR_NONSEQ || live_i.trans == TR_IDLE);
    assign brk_eff = brk_q && !brk_clr;

    // Next-state for the holding register and the burst-break flag.
    always_comb begin
        ctrl_d = ctrl_q;
        brk_d  = brk_q;
        if (cap_en) begin
            ctrl_d = live_i;
        end
        if (cap_en && (live_i.trans == TR_SEQ || live_i.trans == TR_BUSY)) begin
            brk_d = 1'b1;
        end else if (brk_clr) begin
            brk_d = 1'b0;
        end
    end

    // Holding register and burst-break flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            brk_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            brk_q  <= brk_d;
        end
    end

    // Path select then burst-break presentation.
    always_comb begin
        path   = hold ? ctrl_q : live_i;
        ctrl_o = brk_eff ? brk_convert(path) : path;
    end

endmodule

// File: rtl/rsp_s2_dma_ahbic_in.sv
// AHB-Lite input stage: holds a master address phase until the output
// stage grants it and tracks its own data phase for HREADY/HRESP return.
module rsp_s2_dma_ahbic_in
    import rsp_s2_dma_ahbic_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MID_W  = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic [MID_W-1:0]  HMASTERS,
    input  logic              HMASTLOCKS,
    input  logic [ADDR_W-1:0] HWDATAS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    output logic              sel_op,
    output logic [ADDR_W-1:0] addr_op,
    output logic [1:0]        trans_op,
    output logic              write_op,
    output logic [2:0]        size_op,
    output logic [2:0]        burst_op,
    output logic [3:0]        prot_op,
    output logic [MID_W-1:0]  master_op,
    output logic              mastlock_op,
    output logic [ADDR_W-1:0] wdata_op,
    output logic              held_tran_op,
    input  logic              active_op,
    input  logic              readyout_op,
    input  logic              resp_op
);

    in_state_e state_q;
    in_state_e state_d;
    logic      dphase_q;
    logic      dphase_d;
    logic      new_tr;
    logic      hold_reg;
    logic      accept;
    logic      cap_en;
    ahb_ctrl_t live;
    ahb_ctrl_t pres;

    assign new_tr       = HSELS && HTRANSS[1] && HREADYS;
    assign hold_reg     = (state_q == ST_HOLD);
    assign held_tran_op = hold_reg || new_tr;
    assign accept       = held_tran_op && active_op && readyout_op;
    assign cap_en       = !hold_reg && new_tr && !accept;

    assign live.addr     = HADDRS;
    assign live.trans    = htrans_e'(HTRANSS);
    assign live.write    = HWRITES;
    assign live.size     = HSIZES;
    assign live.burst    = HBURSTS;
    assign live.prot     = HPROTS;
    assign live.master   = HMASTERS;
    assign live.mastlock = HMASTLOCKS;

    rsp_s2_dma_ahbic_in_reg u_reg (
        .clk    (HCLK),
        .rst    (HRESET),
        .cap_en (cap_en),
        .hold   (hold_reg),
        .hready (HREADYS),
        .live_i (live),
        .ctrl_o (pres)
    );

    assign sel_op      = held_tran_op;
    assign addr_op     = pres.addr;
    assign trans_op    = held_tran_op ? pres.trans : TR_IDLE;
    assign write_op    = pres.write;
    assign size_op     = pres.size;
    assign burst_op    = pres.burst;
    assign prot_op     = pres.prot;
    assign master_op   = pres.master;
    assign mastlock_op = pres.mastlock;
    assign wdata_op    = HWDATAS;

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: hold an ungranted transfer until it is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cap_en) state_d = ST_HOLD;
            ST_HOLD: if (accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Master-side ready/response: slave view in our data phase, else stall on hold.
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = RESP_OKAY;
        if (dphase_q) begin
            HREADYOUTS = readyout_op;
            HRESPS     = (resp_op == RESP_ERROR) ? RESP_ERROR : RESP_OKAY;
        end else if (state_q == ST_HOLD) begin
            HREADYOUTS = 1'b0;
        end
    end

    // Data phase follows accepted transfers; drops if the bus moves on without one.
    always_comb begin
        dphase_d = dphase_q;
        if (readyout_op) begin
            dphase_d = accept;
        end else if (HREADYS && !accept) begin
            dphase_d = 1'b0;
        end
    end

    // Data-phase flag.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dphase_q <= 1'b0;
        end else begin
            dphase_q <= dphase_d;
        end
    end

endmodule

// File: tb/tb_rsp_s2_dma_ahbic_in.sv
// Directed self-checking bench for the interconnect input stage.
// Each task drives one scenario and checks hand-computed values.
module tb_rsp_s2_dma_ahbic_in;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic [3:0]  HMASTERS;
    logic        HMASTLOCKS;
    logic [31:0] HWDATAS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic [3:0]  master_op;
    logic        mastlock_op;
    logic [31:0] wdata_op;
    logic        held_tran_op;
    logic        active_op;
    logic        readyout_op;
    logic        resp_op;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    rsp_s2_dma_ahbic_in dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTERS(HMASTERS),
        .HMASTLOCKS(HMASTLOCKS), .HWDATAS(HWDATAS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_op(sel_op),
        .addr_op(addr_op), .trans_op(trans_op), .write_op(write_op),
        .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
        .master_op(master_op), .mastlock_op(mastlock_op),
        .wdata_op(wdata_op), .held_tran_op(held_tran_op),
        .active_op(active_op), .readyout_op(readyout_op), .resp_op(resp_op)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        HSELS = 0; HADDRS = 0; HTRANSS = IDLE; HWRITES = 0;
        HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTERS = 4'h5;
        HMASTLOCKS = 0; HWDATAS = 0; HREADYS = 1;
        active_op = 0; readyout_op = 1; resp_op = 0;
    endtask

    task automatic drive(input logic [1:0] tr, input logic [31:0] a,
                         input logic [2:0] b, input logic w);
        HSELS = 1; HTRANSS = tr; HADDRS = a; HBURSTS = b; HWRITES = w;
    endtask

    task automatic test_reset();
        idle_inputs();
        HRESET = 1;
        tick(); tick();
        HRESET = 0;
        HADDRS = 32'hABCD_0000; HWDATAS = 32'h1234_5678; HMASTLOCKS = 1;
        #1;
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL rst_hready got %b exp 1", HREADYOUTS); end
        checks++; if (HRESPS !== 1'b0) begin errors++; $display("FAIL rst_hresp got %b exp 0", HRESPS); end
        checks++; if (held_tran_op !== 1'b0) begin errors++; $display("FAIL rst_held got %b exp 0", held_tran_op); end
        checks++; if (trans_op !== IDLE) begin errors++; $display("FAIL rst_trans got %h exp 0", trans_op); end
        checks++; if (sel_op !== 1'b0) begin errors++; $display("FAIL rst_sel got %b exp 0", sel_op); end
        checks++; if (addr_op !== 32'hABCD_0000) begin errors++; $display("FAIL rst_addr got %h exp abcd0000", addr_op); end
        checks++; if (wdata_op !== 32'h1234_5678) begin errors++; $display("FAIL rst_wdata got %h exp 12345678", wdata_op); end
        checks++; if (mastlock_op !== 1'b1) begin errors++; $display("FAIL rst_lock got %b exp 1", mastlock_op); end
        idle_inputs();
        tick();
    endtask

    task automatic test_live();
        drive(NSEQ, 32'h1000_0040, 3'd0, 1'b1);
        active_op = 1; readyout_op = 1;
        #1;
        checks++; if (addr_op !== 32'h1000_0040) begin errors++; $display("FAIL live_addr got %h exp 10000040", addr_op); end
        checks++; if (trans_op !== NSEQ) begin errors++; $display("FAIL live_trans got %h exp 2", trans_op); end
        checks++; if (sel_op !== 1'b1 || held_tran_op !== 1'b1) begin errors++; $display("FAIL live_sel got %b%b exp 11", sel_op, held_tran_op); end
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL live_hready got %b exp 1", HREADYOUTS); end
        checks++; if (write_op !== 1'b1 || master_op !== 4'h5 || prot_op !== 4'h3 || size_op !== 3'd2) begin errors++; $display("FAIL live_ctrl got %b %h %h %h exp 1 5 3 2", write_op, master_op, prot_op, size_op); end
        tick();
        idle_inputs();
        readyout_op = 0; HREADYS = 0;
        #1;
        checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL live_dphase_wait got %b exp 0", HREADYOUTS); end
        readyout_op = 1; HREADYS = 1;
        #1;
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL live_dphase_done got %b exp 1", HREADYOUTS); end
        tick();
        readyout_op = 0;
        #1;
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL live_no_dphase got %b exp 1", HREADYOUTS); end
        idle_inputs();
        tick();
    endtask

    task automatic test_held();
        drive(NSEQ, 32'h2000_0000, 3'd0, 1'b0);
        active_op = 0;
        #1;
        checks++; if (HREADYOUTS !== 1'b1 || held_tran_op !== 1'b1) begin errors++; $display("FAIL held_c1 got %b%b exp 11", HREADYOUTS, held_tran_op); end
        tick();
        drive(NSEQ, 32'h3000_0000, 3'd0, 1'b1);
        HREADYS = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) active_op = 1;
            #1;
            checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL held_stall[%0d] got %b exp 0", i, HREADYOUTS); end
            checks++; if (addr_op !== 32'h2000_0000) begin errors++; $display("FAIL held_addr[%0d] got %h exp 20000000", i, addr_op); end
            checks++; if (held_tran_op !== 1'b1 || trans_op !== NSEQ || write_op !== 1'b0) begin errors++; $display("FAIL held_ctrl[%0d] got %b %h %b exp 1 2 0", i, held_tran_op, trans_op, write_op); end
            tick();
        end
        idle_inputs();
        readyout_op = 0; HREADYS = 0;
        #1;
        checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL held_dphase got %b exp 0", HREADYOUTS); end
        checks++; if (addr_op !== 32'h0) begin errors++; $display("FAIL held_release got %h exp 0", addr_op); end
        readyout_op = 1; HREADYS = 1;
        tick();
    endtask

    task automatic test_burst();
        drive(NSEQ, 32'h100, 3'd3, 1'b1);
        active_op = 1;
        #1;
        checks++; if (trans_op !== NSEQ || burst_op !== 3'd3) begin errors++; $display("FAIL brst_b1 got %h %h exp 2 3", trans_op, burst_op); end
        tick();
        drive(SEQ, 32'h104, 3'd3, 1'b1);
        active_op = 0;
        #1;
        checks++; if (trans_op !== SEQ || HREADYOUTS !== 1'b1) begin errors++; $display("FAIL brst_b2_live got %h %b exp 3 1", trans_op, HREADYOUTS); end
        tick();
        drive(SEQ, 32'h108, 3'd3, 1'b1);
        HREADYS = 0;
        #1;
        checks++; if (addr_op !== 32'h104 || trans_op !== NSEQ || burst_op !== 3'd0) begin errors++; $display("FAIL brst_b2_hold got %h %h %h exp 104 2 0", addr_op, trans_op, burst_op); end
        checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL brst_stall got %b exp 0", HREADYOUTS); end
        active_op = 1;
        tick();
        HREADYS = 1;
        #1;
        checks++; if (addr_op !== 32'h108 || trans_op !== NSEQ || burst_op !== 3'd0) begin errors++; $display("FAIL brst_b3 got %h %h %h exp 108 2 0", addr_op, trans_op, burst_op); end
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("FAIL brst_b2_data got %b exp 1", HREADYOUTS); end
        tick();
        drive(BUSY, 32'h10C, 3'd3, 1'b1);
        #1;
        checks++; if (trans_op !== IDLE || held_tran_op !== 1'b0) begin errors++; $display("FAIL brst_busy got %h %b exp 0 0", trans_op, held_tran_op); end
        tick();
        drive(SEQ, 32'h10C, 3'd3, 1'b1);
        #1;
        checks++; if (trans_op !== NSEQ || burst_op !== 3'd0) begin errors++; $display("FAIL brst_b4 got %h %h exp 2 0", trans_op, burst_op); end
        tick();
        drive(NSEQ, 32'h200, 3'd1, 1'b0);
        #1;
        checks++; if (trans_op !== NSEQ || burst_op !== 3'd1) begin errors++; $display("FAIL brst_next got %h %h exp 2 1", trans_op, burst_op); end
        tick();
        drive(SEQ, 32'h204, 3'd1, 1'b0);
        #1;
        checks++; if (trans_op !== SEQ || burst_op !== 3'd1) begin errors++; $display("FAIL brst_cleared got %h %h exp 3 1", trans_op, burst_op); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_error();
        logic [3:0] rdy;
        logic [3:0] rsp;
        rdy = 4'b1000;
        rsp = 4'b1100;
        drive(NSEQ, 32'h5000, 3'd0, 1'b0);
        active_op = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            readyout_op = rdy[i]; HREADYS = rdy[i]; resp_op = rsp[i];
            #1;
            checks++; if (HREADYOUTS !== rdy[i]) begin errors++; $display("FAIL err_hready[%0d] got %b exp %b", i, HREADYOUTS, rdy[i]); end
            checks++; if (HRESPS !== rsp[i]) begin errors++; $display("FAIL err_hresp[%0d] got %b exp %b", i, HRESPS, rsp[i]); end
            tick();
        end
        resp_op = 1;
        #1;
        checks++; if (HRESPS !== 1'b0) begin errors++; $display("FAIL err_gated got %b exp 0", HRESPS); end
        idle_inputs();
        tick();
    endtask

    task automatic test_unselected();
        HSELS = 0; HTRANSS = NSEQ; active_op = 1;
        #1;
        checks++; if (held_tran_op !== 1'b0 || HREADYOUTS !== 1'b1 || HRESPS !== 1'b0) begin errors++; $display("FAIL unsel got %b%b%b exp 010", held_tran_op, HREADYOUTS, HRESPS); end
        HSELS = 1; HTRANSS = IDLE;
        #1;
        checks++; if (held_tran_op !== 1'b0 || trans_op !== IDLE) begin errors++; $display("FAIL sel_idle got %b %h exp 0 0", held_tran_op, trans_op); end
        HTRANSS = NSEQ; HREADYS = 0;
        #1;
        checks++; if (held_tran_op !== 1'b0) begin errors++; $display("FAIL not_ready got %b exp 0", held_tran_op); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_in_hold();
        drive(SEQ, 32'h700, 3'd1, 1'b0);
        active_op = 0;
        tick();
        HREADYS = 0;
        #1;
        checks++; if (HREADYOUTS !== 1'b0 || trans_op !== NSEQ) begin errors++; $display("FAIL rh_hold got %b %h exp 0 2", HREADYOUTS, trans_op); end
        HRESET = 1;
        tick();
        HRESET = 0;
        idle_inputs();
        #1;
        checks++; if (HREADYOUTS !== 1'b1 || held_tran_op !== 1'b0) begin errors++; $display("FAIL rh_out got %b%b exp 10", HREADYOUTS, held_tran_op); end
        checks++; if (trans_op !== IDLE || sel_op !== 1'b0) begin errors++; $display("FAIL rh_trans got %h %b exp 0 0", trans_op, sel_op); end
        drive(SEQ, 32'h704, 3'd1, 1'b0);
        active_op = 1;
        #1;
        checks++; if (trans_op !== SEQ || burst_op !== 3'd1) begin errors++; $display("FAIL rh_brk got %h %h exp 3 1", trans_op, burst_op); end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        HRESET = 1;
        idle_inputs();
        test_reset();
        test_live();
        test_held();
        test_burst();
        test_error();
        test_unselected();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsp_s2_dma_ahbic_in.md
Name: rsp_s2_dma_ahbic_in

Overview:
- AHB-Lite input stage for the rsp_s2_dma interconnect. It sits between one master port and the per-slave output stage (rsp_s2_dma_ahbic_out).
- Captures the master's address phase into a holding register whenever the output stage cannot take it immediately. Drives sel/addr/control/held_tran to the output stage and stalls the master via HREADYOUTS until the transfer is accepted.
- Tracks its own data phase so that slave HREADY/HRESP are returned only for transfers it issued.
- Breaks held bursts into legal NONSEQ SINGLE beats.

Parameters:
- ADDR_W, 32, address and data width (fixed 32 in this build; parameter kept for reuse).
- MID_W, 4, HMASTER width.

Ports:
- HCLK  in  1  AHB clock.
- HRESET  in  1  synchronous active-high reset.
- HSELS  in  1  master-side slave select.
- HADDRS  in  32  address.
- HTRANSS  in  2  transfer type.
- HWRITES  in  1  direction.
- HSIZES  in  3  size.
- HBURSTS  in  3  burst.
- HPROTS  in  4  protection.
- HMASTERS  in  4  master ID.
- HMASTLOCKS  in  1  lock.
- HWDATAS  in  32  write data.
- HREADYS  in  1  master-side HREADY (bus-level).
- HREADYOUTS  out  1  ready back to master.
- HRESPS  out  1  response to master.
- sel_op  out  1  to output stage.
- addr_op  out  32  to output stage.
- trans_op  out  2  to output stage.
- write_op  out  1  to output stage.
- size_op  out  3  to output stage.
- burst_op  out  3  to output stage.
- prot_op  out  4  to output stage.
- master_op  out  4  to output stage.
- mastlock_op  out  1  to output stage.
- wdata_op  out  32  to output stage.
- held_tran_op  out  1  valid transfer request.
- active_op  in  1  output stage has granted this port.
- readyout_op  in  1  HREADYMUXM from output stage.
- resp_op  in  1  slave HRESP.

Behaviour:
- Clock/reset: all flops on posedge HCLK. HRESET synchronous active-high, clears every register.
- Reset outputs: HREADYOUTS=1, HRESPS=0, held_tran_op=0, trans_op=IDLE, sel_op=0. All other _op outputs follow the live master inputs.
- Sample condition: new = HSELS & HTRANSS[1] & HREADYS.
- Path select: hold_reg=0 drives outputs combinationally from the live inputs (zero latency). hold_reg=1 drives them from the holding register.
- held_tran_op = hold_reg | new.
- accept = held_tran_op & active_op & readyout_op.
- State machine:
  - IDLE: on new & ~accept, capture all address/control into the register and go to HOLD.
  - HOLD: HREADYOUTS=0, master stalled, HRESPS=0. On accept, go to IDLE and clear hold_reg.
  - No new capture is possible in HOLD, because HREADYS is low while this port stalls the master.
- Data phase:
  - dphase <= accept, updated when readyout_op=1. dphase is also cleared when the master advances with no accepted transfer.
  - While dphase=1: HREADYOUTS=readyout_op, HRESPS=resp_op.
  - Otherwise: HRESPS=0, and HREADYOUTS=~(state==HOLD).
- Simultaneous events:
  - Data phase completes in the same cycle as a HOLD accept: dphase stays 1 for the new transfer.
  - new and accept in the same cycle: no capture, transfer passes live.
- Burst break:
  - When a captured transfer is SEQ or BUSY, set brk. While brk=1, present SEQ as NONSEQ and present burst_op=SINGLE.
  - BUSY is presented as IDLE while brk=1.
  - brk clears on a live NONSEQ or IDLE sampled with HREADYS=1.
- ERROR: the two-cycle ERROR response (resp_op=1) passes through. If the master converts its next transfer to IDLE during cycle 1, it is sampled normally. A captured transfer in HOLD is not cancelled; it completes.
- Lock: mastlock_op follows the selected path unmodified. Locked-sequence holding is done in the output stage.
- Write data: wdata_op=HWDATAS always. The output stage owns data-port selection.
- Reset mid-transfer: hold_reg, brk and dphase clear the next edge. Outputs return to reset values.

Decomposition:
- Shared package rsp_s2_dma_ahbic_pkg: HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HBURST SINGLE=0/INCR=1, HRESP OKAY/ERROR, input-stage state enum.
- Optional sub-module rsp_s2_dma_ahbic_in_reg: holding register plus burst-break conversion.

Test Plan:
- Granted live path: NONSEQ write addr 0x1000_0040, active_op=1, readyout_op=1 -> addr_op=0x1000_0040 same cycle, HREADYOUTS=1, no capture, dphase=1 next cycle.
- Held transfer: NONSEQ read 0x2000_0000 with active_op=0 for 3 cycles, then 1 -> HREADYOUTS=0 for 3 cycles, addr_op held stable at 0x2000_0000, held_tran_op=1, accepted cycle 4.
- Broken INCR4: beat 2 (SEQ, 0x104) held -> trans_op=NONSEQ, burst_op=SINGLE. Beats 3-4 are also NONSEQ/SINGLE. A BUSY during the broken burst is presented as IDLE. A following NONSEQ is passed as-is.
- Slave wait/error: dphase with readyout_op=0 for 2 cycles then resp_op=1 for 2 cycles -> HREADYOUTS mirrors 0,0,0,1 and HRESPS=1 for both error cycles.
- Unselected or IDLE: HSELS=0 or trans IDLE -> held_tran_op=0, HREADYOUTS=1, HRESPS=0.
- Reset in HOLD: assert HRESET one cycle -> next cycle HREADYOUTS=1, held_tran_op=0, trans_op=IDLE, brk=0.
